// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store. Grant and RAM strobes are
// same-cycle combinational, the response comes back exactly one cycle later, and D has priority unless fetch is starved.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [2:0]            d_funct3,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  d_fault,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [2:0]            mem_funct3,
  input  logic [31:0]           mem_data_out,
  input  logic                  mem_fault
);

  localparam int CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t        owner, owner_nxt;
  logic          owner_store, store_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic          fetch_ok;
  logic          fetch_wins;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner       <= OWN_NONE;
      owner_store <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      owner       <= owner_nxt;
      owner_store <= store_nxt;
      starve_cnt  <= starve_nxt;
    end
  end

  always_comb begin
    fetch_ok    = if_req & ~if_flush;
    fetch_wins  = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    mem_funct3  = 3'b000;
    owner_nxt   = OWN_NONE;
    store_nxt   = 1'b0;
    starve_nxt  = starve_cnt;
    if_rvalid   = 1'b0;
    if_rdata    = '0;
    d_rvalid    = 1'b0;
    d_rdata     = '0;
    d_fault     = 1'b0;

    // Everything is held quiet while reset is asserted, including a response already in flight.
    if (rst_n) begin
      if (fetch_ok && (!d_req || fetch_wins)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end

      if (if_gnt) begin
        mem_address = if_addr & WORD_MASK;
        mem_read    = 1'b1;
        mem_funct3  = 3'b010;
        owner_nxt   = OWN_IF;
      end else if (d_gnt) begin
        mem_address = d_addr;
        mem_data_in = d_wdata;
        mem_write   = d_we;
        mem_read    = ~d_we;
        mem_funct3  = d_funct3;
        owner_nxt   = OWN_D;
        store_nxt   = d_we;
      end

      if (!if_req || if_gnt) begin
        starve_nxt = '0;
      end else if (fetch_ok && starve_cnt != LIMIT) begin
        starve_nxt = starve_cnt + 1'b1;
      end

      // Fetch faults are dropped: fetch addresses are in range by construction.
      case (owner)
        OWN_IF: begin
          if_rvalid = ~if_flush;
          if_rdata  = if_flush ? 32'h0 : mem_data_out;
        end
        OWN_D: begin
          d_rvalid = 1'b1;
          d_rdata  = owner_store ? 32'h0 : mem_data_out;
          d_fault  = mem_fault;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM plus a transaction-level reference model, with
// directed scenarios followed by randomized traffic.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          if_req, if_flush, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_fault;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic [2:0]    d_funct3;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data_in;
  logic          mem_write, mem_read;
  logic [2:0]    mem_funct3;
  logic [31:0]   mem_data_out;
  logic          mem_fault;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_fault(d_fault),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_read(mem_read), .mem_funct3(mem_funct3),
    .mem_data_out(mem_data_out), .mem_fault(mem_fault)
  );

  // 64 KiB byte RAM; unwritten bytes read back a fixed address hash.
  bit [7:0] ram_b  [65536];
  bit       ram_wr [65536];
  bit [7:0] ref_b  [65536];
  bit       ref_wr [65536];

  function automatic logic [7:0] init_byte(input int a);
    logic [31:0] x;
    x = a * 32'h9E37_79B1;
    return x[31:24] ^ x[7:0];
  endfunction

  function automatic logic [7:0] rd_byte(input bit from_ref, input int a);
    if (from_ref) return ref_wr[a] ? ref_b[a] : init_byte(a);
    return ram_wr[a] ? ram_b[a] : init_byte(a);
  endfunction

  function automatic bit acc_fault(input logic [31:0] a, input logic [2:0] f3);
    longint la;
    longint sz;
    if (f3[1:0] == 2'b11) return 1'b1;
    la = longint'(a);
    sz = longint'(1) << f3[1:0];
    return ((la % sz) != 0) || (la + sz > 65536);
  endfunction

  function automatic logic [31:0] load_val(input bit from_ref, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int sz;
    v  = '0;
    sz = 1 << f3[1:0];
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rd_byte(from_ref, int'(a[15:0]) + i);
    if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  always @(posedge clk) begin
    mem_fault    <= 1'b0;
    mem_data_out <= '0;
    if (mem_read || mem_write) begin
      if (acc_fault(mem_address, mem_funct3)) begin
        mem_fault <= 1'b1;
      end else if (mem_write) begin
        ram_b[int'(mem_address[15:0])]  <= mem_data_in[7:0];
        ram_wr[int'(mem_address[15:0])] <= 1'b1;
        if (mem_funct3[1:0] != 2'b00) begin
          ram_b[int'(mem_address[15:0]) + 1]  <= mem_data_in[15:8];
          ram_wr[int'(mem_address[15:0]) + 1] <= 1'b1;
        end
        if (mem_funct3[1:0] == 2'b10) begin
          ram_b[int'(mem_address[15:0]) + 2]  <= mem_data_in[23:16];
          ram_wr[int'(mem_address[15:0]) + 2] <= 1'b1;
          ram_b[int'(mem_address[15:0]) + 3]  <= mem_data_in[31:24];
          ram_wr[int'(mem_address[15:0]) + 3] <= 1'b1;
        end
      end else begin
        mem_data_out <= load_val(1'b0, mem_address, mem_funct3);
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: consecutive fetch losses plus the one transaction awaiting its response.
  int          losses    = 0;
  int          pend_kind = 0;  // 0 none, 1 fetch, 2 data
  logic [31:0] pend_data = '0;
  bit          pend_fault = 1'b0;
  bit          exp_if_g, exp_d_g;

  task automatic check_cycle();
    bit fok, exp_irv, exp_drv;
    #2;
    exp_if_g = 1'b0;
    exp_d_g  = 1'b0;
    if (rst_n) begin
      fok = if_req && !if_flush;
      if (fok && (!d_req || (LIMIT > 0 && losses >= LIMIT))) exp_if_g = 1'b1;
      else if (d_req) exp_d_g = 1'b1;
    end
    chk("if_gnt", if_gnt, exp_if_g);
    chk("d_gnt", d_gnt, exp_d_g);
    chk("mem_read", mem_read, exp_if_g || (exp_d_g && !d_we));
    chk("mem_write", mem_write, exp_d_g && d_we);
    if (exp_if_g) begin
      chk("mem_address_if", mem_address, {if_addr[31:2], 2'b00});
      chk("mem_funct3_if", mem_funct3, 3'b010);
      chk("mem_data_in_if", mem_data_in, 32'h0);
    end else if (exp_d_g) begin
      chk("mem_address_d", mem_address, d_addr);
      chk("mem_funct3_d", mem_funct3, d_funct3);
      chk("mem_data_in_d", mem_data_in, d_wdata);
    end else if (!rst_n) begin
      chk("mem_address_rst", mem_address, 32'h0);
    end
    exp_irv = rst_n && pend_kind == 1 && !if_flush;
    exp_drv = rst_n && pend_kind == 2;
    chk("if_rvalid", if_rvalid, exp_irv);
    chk("if_rdata", if_rdata, exp_irv ? pend_data : 32'h0);
    chk("d_rvalid", d_rvalid, exp_drv);
    chk("d_rdata", d_rdata, exp_drv ? pend_data : 32'h0);
    chk("d_fault", d_fault, exp_drv && pend_fault);
  endtask

  task automatic advance();
    int sz;
    if (!rst_n) begin
      losses    = 0;
      pend_kind = 0;
    end else begin
      pend_kind  = 0;
      pend_fault = 1'b0;
      pend_data  = '0;
      if (exp_if_g) begin
        pend_kind = 1;
        pend_data = load_val(1'b1, {if_addr[31:2], 2'b00}, 3'b010);
      end else if (exp_d_g) begin
        pend_kind  = 2;
        pend_fault = acc_fault(d_addr, d_funct3);
        if (d_we) begin
          if (!pend_fault) begin
            sz = 1 << d_funct3[1:0];
            for (int i = 0; i < sz; i++) begin
              ref_b[int'(d_addr[15:0]) + i]  = d_wdata[8*i +: 8];
              ref_wr[int'(d_addr[15:0]) + i] = 1'b1;
            end
          end
        end else if (!pend_fault) begin
          pend_data = load_val(1'b1, d_addr, d_funct3);
        end
      end
      if (!if_req || exp_if_g) losses = 0;
      else if (!if_flush) losses = (losses < LIMIT) ? losses + 1 : LIMIT;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    check_cycle();
    advance();
  endtask

  logic [2:0] ld_opts [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] st_opts [3] = '{3'b000, 3'b001, 3'b010};

  initial begin
    logic [5:0]  if_pat;
    logic [31:0] a;
    int          sz;

    rst_n = 1'b0; if_req = 1'b1; if_flush = 1'b0; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = 32'h0; d_funct3 = 3'b010;
    @(posedge clk);
    #1;

    // Reset with both requesters active: nothing is granted or returned.
    check_cycle();
    chk("rst_if_gnt", if_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    advance();
    step();
    rst_n = 1'b1;
    check_cycle();
    chk("post_rst_d_gnt", d_gnt, 1'b1);
    advance();
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Fetch from an unaligned address is issued word-aligned.
    if_req = 1'b1; if_addr = 32'h0000_0106;
    check_cycle();
    chk("fetch_addr", mem_address, 32'h104);
    chk("fetch_funct3", mem_funct3, 3'b010);
    advance();
    if_req = 1'b0;
    check_cycle();
    chk("fetch_rvalid", if_rvalid, 1'b1);
    chk("fetch_rdata", if_rdata, load_val(1'b1, 32'h104, 3'b010));
    advance();

    // Six cycles of conflict: fetch wins only on the fifth.
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_funct3 = 3'b010;
    if_pat = 6'b010000;
    for (int k = 0; k < 6; k++) begin
      check_cycle();
      chk("conflict_if_gnt", if_gnt, if_pat[k]);
      chk("conflict_d_gnt", d_gnt, !if_pat[k]);
      advance();
    end
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Store then load back-to-back to the same word.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
    step();
    d_we = 1'b0; d_wdata = 32'h0;
    check_cycle();
    chk("sw_rvalid", d_rvalid, 1'b1);
    chk("sw_rdata", d_rdata, 32'h0);
    advance();
    d_req = 1'b0;
    check_cycle();
    chk("lw_rvalid", d_rvalid, 1'b1);
    chk("lw_rdata", d_rdata, 32'hDEAD_BEEF);
    advance();

    // Flush squashes the pending fetch response and blocks a new fetch grant.
    if_req = 1'b1; if_addr = 32'h200;
    check_cycle();
    chk("flush_pre_gnt", if_gnt, 1'b1);
    advance();
    if_flush = 1'b1;
    check_cycle();
    chk("flush_rvalid", if_rvalid, 1'b0);
    chk("flush_gnt", if_gnt, 1'b0);
    advance();
    if_flush = 1'b0; if_req = 1'b0;
    step();

    // Misaligned word load at the top of RAM faults.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_FFFE; d_funct3 = 3'b010;
    step();
    d_req = 1'b0;
    check_cycle();
    chk("fault_rvalid", d_rvalid, 1'b1);
    chk("fault_flag", d_fault, 1'b1);
    chk("fault_rdata", d_rdata, 32'h0);
    advance();

    // A fetch in flight when reset hits is dropped.
    if_req = 1'b1; if_addr = 32'h300;
    step();
    if_req = 1'b0; rst_n = 1'b0;
    check_cycle();
    chk("rst_drop_rvalid", if_rvalid, 1'b0);
    advance();
    rst_n = 1'b1;
    step();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      if_req   = ($urandom_range(0, 99) < 60);
      if_flush = ($urandom_range(0, 99) < 10);
      if_addr  = 32'($urandom_range(0, 65535));
      d_req    = ($urandom_range(0, 99) < 55);
      d_we     = $urandom_range(0, 1) == 1;
      d_funct3 = d_we ? st_opts[$urandom_range(0, 2)] : ld_opts[$urandom_range(0, 4)];
      d_wdata  = $urandom;
      sz       = 1 << d_funct3[1:0];
      a        = 32'($urandom_range(0, 65535));
      if ($urandom_range(0, 9) != 0) a = a & ~32'(sz - 1);
      if ($urandom_range(0, 29) == 0) a = a | 32'h0001_0000;
      d_addr = a;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
